// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB slave front-end for an on-chip SRAM with programmable wait states
// Optional macro AHB_SLV_ERR_EN: two-cycle ERROR response for out-of-region or misaligned transfers.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_mem_slave #(
    parameter int          ADDR_W      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       HSel,
    input  logic [31:0]                HAddress,
    input  logic [31:0]                HWrite_data,
    input  logic [`AHB_TRANS_BITS-1:0] HTrans,
    input  logic [`AHB_SIZE_BITS-1:0]  HSize,
    input  logic                       HWrite,
    input  logic                       HReady_in,
    output logic [31:0]                HRead_data,
    output logic                       HReady,
    output logic [1:0]                 HResp,
    output logic                       MEM_CS,
    output logic                       MEM_OE,
    output logic [3:0]                 MEM_WEB,
    output logic [ADDR_W-1:0]          MEM_A,
    output logic [31:0]                MEM_DI,
    input  logic [31:0]                MEM_DO
);

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              slv_ready;
    logic              cap;
    logic              cap_err;
    logic              wr_now;
    logic              rd_done;
    logic              rd_early;
    logic              rd_wait;
    logic [1:0]        cap_size;
    logic [ADDR_W+1:0] cap_addr;
    logic [3:0]        lanes;
    logic              unused_bits;

    always_comb begin
        cap_size = (HSize >= `AHB_SIZE_BITS'(2)) ? 2'd2 : HSize[1:0];
        cap_addr = HAddress[ADDR_W+1:0];
        if (cap_size == 2'd1) cap_addr[0]   = 1'b0;
        if (cap_size == 2'd2) cap_addr[1:0] = 2'b00;
    end

`ifdef AHB_SLV_ERR_EN
    assign cap_err = (HAddress[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) ||
                     ((cap_size == 2'd1) && HAddress[0]) ||
                     ((cap_size == 2'd2) && (HAddress[1:0] != 2'b00));
    assign unused_bits = ^{HTrans, BASE_ADDR};
`else
    assign cap_err     = 1'b0;
    assign unused_bits = ^{HTrans, HAddress[31:ADDR_W+2], BASE_ADDR};
`endif

    assign slv_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign wr_now    = (state_q == ST_DONE) && write_q;
    assign rd_done   = (state_q == ST_DONE) && !write_q;
    assign cap       = rst && HSel && HReady_in && HTrans[1] && slv_ready;
    // With no wait states a read must reach the SRAM in its address phase, unless a write owns the port.
    assign rd_early  = cap && !HWrite && !cap_err && !HAS_WAIT && !wr_now;
    assign rd_wait   = (state_q == ST_WAIT) && (cnt_q == 3'd0) && !write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        rdata_d = rd_done ? MEM_DO : rdata_q;
        if (cap) begin
            addr_d  = cap_addr;
            size_d  = cap_size;
            write_d = HWrite;
            cnt_d   = WAIT_INIT;
            if (cap_err) begin
                state_d = ST_ERR1;
            end else if (HAS_WAIT || (!HWrite && wr_now)) begin
                // Zero-wait read colliding with a write: one stall cycle to issue the read.
                state_d = ST_WAIT;
            end else begin
                state_d = ST_DONE;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd0) state_d = ST_DONE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                ST_ERR1: state_d = ST_ERR2;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    lanes = 4'b0001 << addr_q[1:0];
            2'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        HReady     = slv_ready;
        HResp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
        HRead_data = rd_done ? MEM_DO : rdata_q;
        MEM_CS     = rd_early || rd_wait || wr_now;
        MEM_OE     = rd_early || rd_wait;
        MEM_A      = rd_early ? cap_addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
        MEM_WEB    = wr_now ? ~lanes : 4'hF;
        MEM_DI     = wr_now ? HWrite_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - directed bench: one-wait and zero-wait ahb_mem_slave instances with SRAM models
module tb_ahb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel1, hsel0;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;

    logic [31:0] rdata1, rdata0;
    logic        hready1, hready0;
    logic [1:0]  hresp1, hresp0;
    logic        cs1, cs0, oe1, oe0;
    logic [3:0]  web1, web0;
    logic [13:0] a1, a0;
    logic [31:0] di1, di0, do1, do0;

    logic [31:0] mem1 [0:16383];
    logic [31:0] mem0 [0:16383];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_mem_slave #(.ADDR_W(14), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .HSel(hsel1), .HAddress(haddr), .HWrite_data(hwdata),
        .HTrans(htrans), .HSize(hsize), .HWrite(hwrite), .HReady_in(hready1),
        .HRead_data(rdata1), .HReady(hready1), .HResp(hresp1), .MEM_CS(cs1), .MEM_OE(oe1),
        .MEM_WEB(web1), .MEM_A(a1), .MEM_DI(di1), .MEM_DO(do1)
    );

    ahb_mem_slave #(.ADDR_W(14), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .HSel(hsel0), .HAddress(haddr), .HWrite_data(hwdata),
        .HTrans(htrans), .HSize(hsize), .HWrite(hwrite), .HReady_in(hready0),
        .HRead_data(rdata0), .HReady(hready0), .HResp(hresp0), .MEM_CS(cs0), .MEM_OE(oe0),
        .MEM_WEB(web0), .MEM_A(a0), .MEM_DI(di0), .MEM_DO(do0)
    );

    always @(posedge clk) begin
        if (cs1 && oe1) do1 <= mem1[a1];
        if (cs1) for (int b = 0; b < 4; b++) if (!web1[b]) mem1[a1][8*b +: 8] <= di1[8*b +: 8];
        if (cs0 && oe0) do0 <= mem0[a0];
        if (cs0) for (int b = 0; b < 4; b++) if (!web0[b]) mem0[a0][8*b +: 8] <= di0[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer1(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [3:0] exp_web, input logic [13:0] exp_a,
                         input logic [31:0] exp_rd);
        hsel1 = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        @(negedge clk);
        chk({tag, "_aph_rdy"}, 32'(hready1), 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = wdata;
        @(negedge clk);
        chk({tag, "_wait_rdy"}, 32'(hready1), 32'd0);
        chk({tag, "_wait_cs"}, 32'(cs1), 32'(!wr));
        if (!wr) chk({tag, "_wait_a"}, 32'(a1), 32'(exp_a));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_rdy"}, 32'(hready1), 32'd1);
        chk({tag, "_done_resp"}, 32'(hresp1), 32'd0);
        if (wr) begin
            chk({tag, "_web"}, 32'(web1), 32'(exp_web));
            chk({tag, "_a"}, 32'(a1), 32'(exp_a));
            chk({tag, "_di"}, di1, wdata);
        end else begin
            chk({tag, "_rdata"}, rdata1, exp_rd);
        end
        @(posedge clk); #1;
        hsel1 = 1'b0;
    endtask

    logic [31:0] wd [3];
    logic [31:0] exp_a8;

    initial begin
        wd[0] = 32'hA0A0_0000; wd[1] = 32'hB1B1_0001; wd[2] = 32'hC2C2_0002;
        rst = 1'b0; hsel1 = 1'b0; hsel0 = 1'b0; haddr = '0; hwdata = '0;
        htrans = 2'b00; hsize = 3'd2; hwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(hready1), 32'd1);
        chk("rst_resp", 32'(hresp1), 32'd0);
        chk("rst_web", 32'(web1), 32'hF);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_cs", 32'(cs1), 32'd0);
        chk("rst_a", 32'(a1), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        xfer1("wr_word", 32'h1000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'h0, 14'd4, 32'h0);
        xfer1("rd_word", 32'h1000_0010, 1'b0, 3'd2, 32'h0, 4'hF, 14'd4, 32'hDEAD_BEEF);
        xfer1("wr_byte", 32'h1000_0013, 1'b1, 3'd0, 32'h5500_0000, 4'h7, 14'd4, 32'h0);
        xfer1("rd_byte", 32'h1000_0010, 1'b0, 3'd2, 32'h0, 4'hF, 14'd4, 32'h55AD_BEEF);
        xfer1("wr_half", 32'h1000_0012, 1'b1, 3'd1, 32'h1234_0000, 4'h3, 14'd4, 32'h0);
        xfer1("rd_half", 32'h1000_0010, 1'b0, 3'd2, 32'h0, 4'hF, 14'd4, 32'h1234_BEEF);
        xfer1("wr_size3", 32'h1000_0020, 1'b1, 3'd3, 32'h0BAD_F00D, 4'h0, 14'd8, 32'h0);
        xfer1("wr_base0", 32'h1000_0000, 1'b1, 3'd2, 32'hCAFE_0001, 4'h0, 14'd0, 32'h0);

`ifdef AHB_SLV_ERR_EN
        exp_a8 = 32'h0BAD_F00D;
        hsel1 = 1'b1; htrans = 2'b10; haddr = 32'h2000_0000; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        chk("err1_rdy", 32'(hready1), 32'd0);
        chk("err1_resp", 32'(hresp1), 32'd1);
        chk("err1_cs", 32'(cs1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err2_rdy", 32'(hready1), 32'd1);
        chk("err2_resp", 32'(hresp1), 32'd1);
        chk("err2_cs", 32'(cs1), 32'd0);
        @(posedge clk); #1;
        hsel1 = 1'b0;
`else
        exp_a8 = 32'h0BAD_7777;
        xfer1("rd_oor", 32'h2000_0000, 1'b0, 3'd2, 32'h0, 4'hF, 14'd0, 32'hCAFE_0001);
        xfer1("wr_misal", 32'h1000_0021, 1'b1, 3'd1, 32'h0000_7777, 4'hC, 14'd8, 32'h0);
`endif

        hsel1 = 1'b1; haddr = 32'h1000_0010; hwrite = 1'b1;
        for (int t = 0; t < 2; t++) begin
            htrans = (t == 0) ? 2'b00 : 2'b01;
            @(negedge clk);
            chk("idle_busy_rdy", 32'(hready1), 32'd1);
            chk("idle_busy_resp", 32'(hresp1), 32'd0);
            chk("idle_busy_cs", 32'(cs1), 32'd0);
            chk("idle_busy_web", 32'(web1), 32'hF);
            @(posedge clk); #1;
        end
        hsel1 = 1'b0; htrans = 2'b00;

        hsel1 = 1'b1; htrans = 2'b10; haddr = 32'h1000_0020; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("midrst_wait_rdy", 32'(hready1), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_rdy", 32'(hready1), 32'd1);
        chk("midrst_resp", 32'(hresp1), 32'd0);
        chk("midrst_web", 32'(web1), 32'hF);
        chk("midrst_rdata", rdata1, 32'h0);
        chk("midrst_cs", 32'(cs1), 32'd0);
        hsel1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        xfer1("rd_after_rst", 32'h1000_0020, 1'b0, 3'd2, 32'h0, 4'hF, 14'd8, exp_a8);

        hsel0 = 1'b1; hwrite = 1'b1; hsize = 3'd2;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                haddr = 32'h1000_0000 + 32'(4 * i);
                htrans = (i == 0) ? 2'b10 : 2'b11;
            end else begin
                htrans = 2'b00;
            end
            if (i > 0) hwdata = wd[i-1];
            @(negedge clk);
            chk("b2b_wr_rdy", 32'(hready0), 32'd1);
            if (i > 0) begin
                chk("b2b_wr_web", 32'(web0), 32'h0);
                chk("b2b_wr_a", 32'(a0), 32'(i - 1));
                chk("b2b_wr_di", di0, wd[i-1]);
            end
            @(posedge clk); #1;
        end
        hsel0 = 1'b0;
        @(posedge clk); #1;

        hsel0 = 1'b1; hwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                haddr = 32'h1000_0000 + 32'(4 * i);
                htrans = (i == 0) ? 2'b10 : 2'b11;
            end else begin
                htrans = 2'b00;
            end
            @(negedge clk);
            chk("b2b_rd_rdy", 32'(hready0), 32'd1);
            if (i < 3) begin
                chk("b2b_rd_cs", 32'(cs0 && oe0), 32'd1);
                chk("b2b_rd_a", 32'(a0), 32'(i));
            end
            if (i > 0) chk("b2b_rd_data", rdata0, wd[i-1]);
            @(posedge clk); #1;
        end
        hsel0 = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
AHB slave wrapper at the memory end of the shared bus; the responder for the CPU-side master wrappers. Decodes AHB address/data phases, drives an on-chip SRAM macro with byte-lane write strobes, and returns HRead_data/HReady/HResp with a programmable number of wait states. One instance sits in front of each IM/DM SRAM.

Parameters:
ADDR_W, 14, SRAM word-address width (depth 2^ADDR_W words)
BASE_ADDR, 32'h10000000, slave base address; region size 2^(ADDR_W+2) bytes
WAIT_CYCLES, 1, HReady-low cycles per data phase (0..7)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
HSel  input  1  slave select from decoder
HAddress  input  32  byte address (address phase)
HWrite_data  input  32  write data (data phase)
HTrans  input  `AHB_TRANS_BITS  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HSize  input  `AHB_SIZE_BITS  0 byte, 1 half, 2 word
HWrite  input  1  1 = write
HReady_in  input  1  bus-level HReady (previous transfer done)
HRead_data  output  32  read data
HReady  output  1  slave ready
HResp  output  2  00 OKAY, 01 ERROR
MEM_CS  output  1  SRAM chip select, active-high
MEM_OE  output  1  SRAM output enable, active-high
MEM_WEB  output  4  per-byte write enable, active-low
MEM_A  output  ADDR_W  SRAM word address
MEM_DI  output  32  SRAM write data
MEM_DO  input  32  SRAM read data (valid cycle after CS with OE)

Behaviour:
- Reset (rst=0, async): state IDLE, HReady=1, HResp=00, HRead_data=0, MEM_CS=0, MEM_OE=0, MEM_WEB=4'hF, MEM_A=0, MEM_DI=0, wait counter 0.
- Capture: address phase accepted when HSel && HReady_in && HTrans[1]; registers addr, size, write. IDLE/BUSY or HSel=0: no capture, next data phase OKAY zero-wait.
- States: IDLE, WAIT, DONE, ERR1, ERR2.
- IDLE: HReady=1, HResp=00. On capture -> WAIT if WAIT_CYCLES>0 else DONE; -> ERR1 if capture is flagged error (see Optional Feature).
- WAIT: HReady=0; counter counts WAIT_CYCLES-1 down to 0, then -> DONE. Read: MEM_CS=1, MEM_OE=1, MEM_A=addr[ADDR_W+1:2] in last WAIT cycle.
- DONE: HReady=1, HResp=00. Read: HRead_data=MEM_DO (full word; master selects lanes). Write: MEM_CS=1, MEM_DI=HWrite_data, MEM_WEB lanes low per size: byte -> lane addr[1:0]; half -> lanes {1,0} if addr[1]=0 else {3,2}; word -> 4'h0. New capture in DONE -> WAIT/DONE/ERR1 (back-to-back pipelining, no idle bubble); else -> IDLE.
- WAIT_CYCLES=0 read: MEM_CS/OE issued combinationally in capture cycle from HAddress so MEM_DO valid in DONE.
- ERR1: HReady=0, HResp=01, no SRAM access. ERR2: HReady=1, HResp=01; capture allowed as in DONE.
- HRead_data holds last value outside DONE reads; 0 after reset.
- Outside WAIT/DONE: MEM_CS=0, MEM_WEB=4'hF.
- Reset mid-transfer: aborts immediately, no partial write completes after rst deasserts.
- HSize >2: treated as word.

Optional Feature:
Macro AHB_SLV_ERR_EN. Defined: capture flagged error when HAddress[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2], or misaligned (half with addr[0]=1, word with addr[1:0]!=0); two-cycle ERROR response (ERR1, ERR2), no SRAM access. Not defined: upper address bits ignored, misaligned low bits forced to alignment, HResp constant 00, ERR states unreachable.

Test Plan:
- Reset: rst low mid-WAIT -> HReady=1, HResp=00, MEM_WEB=4'hF, HRead_data=0 immediately.
- Word write 0x10000010 data 0xDEADBEEF, WAIT_CYCLES=1 -> one HReady-low cycle, then MEM_A=4, MEM_WEB=4'h0, MEM_DI=0xDEADBEEF; readback returns 0xDEADBEEF.
- Byte write 0x55 at 0x10000013 then word read -> MEM_WEB=4'h7; readback 0x55ADBEEF.
- Back-to-back NONSEQ reads addr 0x0,0x4,0x8, WAIT_CYCLES=0 -> HReady constantly 1, data returned on consecutive cycles.
- AHB_SLV_ERR_EN: word read at 0x20000000 -> HReady 0 then 1 with HResp=01 both cycles, MEM_CS stays 0; same without macro -> OKAY, MEM_A=0.
- IDLE/BUSY HTrans with HSel=1 -> OKAY, HReady=1, no SRAM activity.
